imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// Write-side companion to the instruction ROM: streams a program into the instruction RAM over a byte interface.
// Assembles little-endian bytes into N-bit words and writes them at ascending addresses from 0.
// Holds the processor in reset until the load completes.
// Sits between the host/debug byte link and the instruction memory write port.
// PARAMETERS
// N       32  instruction word width; must be a multiple of 8 (BPW = N/8 bytes per word)
// ADDR_W  6   word address width; DEPTH = 2**ADDR_W = 64 words
// PORTS
// clk         in   1         rising-edge clock
// reset       in   1         synchronous, active-high
// start       in   1         begin a load; sampled in IDLE and DONE only
// num_words   in   ADDR_W+1  words to load; sampled on accepted start
// byte_valid  in   1         byte_data valid
// byte_data   in   8         program byte, LS byte of each word first
// byte_ready  out  1         loader accepts byte this cycle (handshake = valid & ready)
// wr_en       out  1         instruction memory write strobe, one cycle per word
// wr_addr     out  ADDR_W    word write address
// wr_data     out  N         assembled word
// busy        out  1         state == LOAD
// done        out  1         sticky: load complete
// cpu_reset   out  1         hold processor in reset; low only in DONE
// BEHAVIOUR
// - Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cpu_reset=1. FSM -> IDLE.
// - Any partial word is discarded on reset.
// - FSM states IDLE, LOAD, DONE.
// - IDLE + start: latch len = min(num_words, DEPTH).
//   - len == 0: -> DONE next cycle, no writes.
//   - len > 0: -> LOAD with word index 0 and byte index 0.
// - LOAD:
//   - byte_ready = 1 except in the wr_en cycle (one-cycle bubble per word).
//   - Each handshake stores byte_data into bits [8*b+7:8*b], where b is the byte index; b increments.
//   - byte_valid while byte_ready=0: byte is not consumed and must be held by the source.
// - Word write, on handshake of byte BPW-1:
//   - Next cycle: wr_en=1, wr_data = assembled word, wr_addr = word index.
//   - Byte index clears.
//   - Word index increments after the write; no wrap is possible because len <= DEPTH.
// - Last word (index == len-1):
//   - The wr_en cycle moves the FSM to DONE.
//   - done=1 and cpu_reset=0 from the following cycle.
// - start during LOAD is ignored.
// - DONE: done=1, cpu_reset=0, byte_ready=0.
//   - start -> LOAD as from IDLE: done clears, cpu_reset reasserts the next cycle, indexes clear.
// - wr_addr and wr_data hold their values between strobes; only wr_en qualifies them.
// - num_words > DEPTH clamps to DEPTH. Bytes beyond the program are never accepted.
// CONFIGURATION
// - IMEM_LOADER_CSUM_EN defined:
//   - Adds outputs csum[7:0] and csum_err.
//   - csum = sum mod 256 of all program bytes accepted in this load; cleared on start and on reset.
//   - After the last word write, the FSM enters CHK. byte_ready=1 for one trailing byte.
//   - On its handshake: if the byte != csum, then csum_err=1, cpu_reset stays 1 and done=1. Otherwise csum_err=0, same as normal DONE.
//   - csum_err is sticky until start or reset.
// - IMEM_LOADER_CSUM_EN undefined:
//   - No csum ports and no CHK state.
//   - DONE directly after the last write, as described above.
// TESTING
// - Reset, start with num_words=2, bytes 00 00 00 f8 01 80 00 f8, byte_valid held high:
//   - wr_en at addr 0 data 32'hf8000000, then addr 1 data 32'hf8008001.
//   - Each wr_en cycle has byte_ready=0.
//   - done=1 and cpu_reset=0 two cycles after the last byte.
// - start with num_words=0 -> no wr_en, done=1 next cycle, byte_ready never 1.
// - start with num_words=100, continuous bytes -> exactly 64 writes, addr 0..63.
//   - The 257th offered byte is never accepted.
// - Reset after 2 bytes of word 0 -> no wr_en, cpu_reset=1, busy=0.
//   - Restart with num_words=1 and bytes 0b 00 00 14 -> addr 0 gets 32'h1400000b.
// - byte_valid toggled 1,0,1,0 mid-word, plus valid asserted during the wr_en bubble:
//   - No byte lost or duplicated.
//   - Words match the reference image.
// - CSUM_EN, 1 word f8000000 (bytes 00 00 00 f8), trailing byte f8:
//   - csum_err=0, cpu_reset=0.
//   - With trailing byte f7 instead: csum_err=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Streams a program from a byte link into the instruction RAM write port.
// Bytes arrive least-significant first and are packed into N-bit words.
// Each word is written once, at ascending word addresses starting from 0.
// The processor is held in reset until the load has finished.
//
// Optional feature (macro IMEM_LOADER_CSUM_EN):
//   After the last word, one trailing checksum byte is accepted and compared
//   with the mod-256 sum of all program bytes. A mismatch sets csum_err and
//   keeps cpu_reset asserted.
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         begin a load (taken in IDLE or DONE only)
//   num_words     number of words to load, clamped to DEPTH
//   byte_valid    byte_data carries a byte
//   byte_data     program byte
//   byte_ready    loader takes a byte this cycle
//   wr_en         one-cycle write strobe per word
//   wr_addr       word address (held between strobes)
//   wr_data       assembled word (held between strobes)
//   busy          a word load is in progress
//   done          load complete (sticky until the next start)
//   cpu_reset     processor reset; low only after a clean load
//   csum, csum_err  running checksum and mismatch flag (feature only)
//
// Byte handshake: a byte moves when byte_valid and byte_ready are both high
// on a rising edge. byte_ready never depends on byte_valid, and a source
// that sees byte_ready low must hold its byte until it is taken.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_reset
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic [7:0]        csum,
  output logic              csum_err
`endif
);

  localparam int BPW    = N / 8;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [ADDR_W:0]   DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_1  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [BIDX_W-1:0] LAST_B = BIDX_W'(BPW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
`ifdef IMEM_LOADER_CSUM_EN
    ,
    S_CHK  = 2'd3
`endif
  } state_t;

  // state is left as a named variable so checkers can bind to it directly
  state_t state, state_next;

  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_in;
  logic [ADDR_W-1:0] word_idx;
  logic [BIDX_W-1:0] byte_idx;
  logic [N-1:0]      word_buf;
  logic [N-1:0]      asm_word;
  logic              start_ok;
  logic              hs;
  logic              last_byte;
  logic              last_word;

  // ---------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------
  always_comb begin
    len_in   = (num_words > DEPTH) ? DEPTH : num_words;
    start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // The wr_en cycle is a deliberate bubble: no byte is taken while a
    // word is being written.
    byte_ready = 1'b0;
    if (state == S_LOAD) begin
      byte_ready = !wr_en;
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (state == S_CHK) begin
      byte_ready = 1'b1;
    end
`endif

    hs        = byte_valid && byte_ready;
    last_byte = (byte_idx == LAST_B);
    // len is never 0 while in LOAD, so len-1 cannot underflow here
    last_word = ({1'b0, word_idx} == (len - LEN_1));

    // The word as it will look once the current byte is merged in
    asm_word = word_buf;
    asm_word[8*byte_idx +: 8] = byte_data;

    busy = (state == S_LOAD);
    done = (state == S_DONE);
`ifdef IMEM_LOADER_CSUM_EN
    cpu_reset = !((state == S_DONE) && !csum_err);
`else
    cpu_reset = !(state == S_DONE);
`endif
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = (len_in == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (wr_en && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CHK: begin
        if (hs) begin
          state_next = S_DONE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: byte assembly, write strobe, indexes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum     <= '0;
      csum_err <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (start_ok) begin
        len      <= len_in;
        word_idx <= '0;
        byte_idx <= '0;
        word_buf <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum     <= '0;
        csum_err <= 1'b0;
`endif
      end else begin
        if ((state == S_LOAD) && hs) begin
          word_buf <= asm_word;
`ifdef IMEM_LOADER_CSUM_EN
          csum     <= csum + byte_data;
`endif
          if (last_byte) begin
            byte_idx <= '0;
            wr_en    <= 1'b1;
            wr_data  <= asm_word;
            wr_addr  <= word_idx;
          end else begin
            byte_idx <= byte_idx + BIDX_W'(1);
          end
        end
        // Advance after the strobe so wr_addr above saw the current index
        if ((state == S_LOAD) && wr_en) begin
          word_idx <= word_idx + ADDR_W'(1);
        end
`ifdef IMEM_LOADER_CSUM_EN
        if ((state == S_CHK) && hs) begin
          csum_err <= (byte_data != csum);
        end
`endif
      end
    end
  end

endmodule
